bnn_layer_sequencer: RTL and testbench

- Parametrised successor to the fixed 4-layer binary NN compute FSM.
- Sequences NUM_LAYERS fully connected binarised layers: first layer IN_LEN→HID_LEN, hidden layers HID_LEN→HID_LEN, last layer HID_LEN→OUT_LEN.
- Uses an XNOR-popcount datapath with a sign activation and writes each activation bit back to the x-memory banks.
- Adds a start/done handshake and an argmax classifier on the last layer, replacing first-one detection.

---
 rtl/bnn_layer_sequencer_if.sv | 34 +++
 rtl/bnn_layer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_layer_sequencer_if.sv
// Handshake and memory-port bundle for the binarised layer sequencer.
// The master modport is the sequencer; the slave modport is the host/memory side.
interface bnn_layer_sequencer_if #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int SEL_LEN    = 2,
  parameter int CLS_W      = 4
) ();
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [CLS_W-1:0]      class_idx;
  logic                  class_valid;
  logic [W_ADDR_LEN-1:0] w_addr;
  logic [SEL_LEN-1:0]    w_sel;
  logic                  w_data;
  logic [X_ADDR_LEN-1:0] x_addr;
  logic [SEL_LEN-1:0]    x_sel;
  logic                  x_rd_data;
  logic                  x_wr_en;
  logic                  x_wr_data;

  modport master (
    input  start, w_data, x_rd_data,
    output busy, done, class_idx, class_valid,
           w_addr, w_sel, x_addr, x_sel, x_wr_en, x_wr_data
  );

  modport slave (
    output start, w_data, x_rd_data,
    input  busy, done, class_idx, class_valid,
           w_addr, w_sel, x_addr, x_sel, x_wr_en, x_wr_data
  );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Sequences NUM_LAYERS binarised fully connected layers through an XNOR-popcount
// datapath; hidden activations go back to x-memory, the last layer feeds an argmax.
module bnn_layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int IN_LEN     = 784,
  parameter int HID_LEN    = 1024,
  parameter int OUT_LEN    = 10,
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int SEL_LEN    = 2,
  parameter int ACC_W      = 11,
  parameter int CLS_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bnn_layer_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ACC_W-1:0]      IN_F      = ACC_W'(IN_LEN);
  localparam logic [ACC_W-1:0]      HID_F     = ACC_W'(HID_LEN);
  localparam logic [X_ADDR_LEN-1:0] IN_LAST   = X_ADDR_LEN'(IN_LEN - 1);
  localparam logic [X_ADDR_LEN-1:0] HID_LAST  = X_ADDR_LEN'(HID_LEN - 1);
  localparam logic [X_ADDR_LEN-1:0] OUT_LAST  = X_ADDR_LEN'(OUT_LEN - 1);
  localparam logic [SEL_LEN-1:0]    LAST_LAYER = SEL_LEN'(NUM_LAYERS - 1);

  logic [2:0]            state_q, state_d;
  logic [SEL_LEN-1:0]    layer_q, layer_d;
  logic [X_ADDR_LEN-1:0] neuron_q, neuron_d;
  logic [X_ADDR_LEN-1:0] idx_q, idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [W_ADDR_LEN-1:0] base_q, base_d;
  logic [ACC_W-1:0]      best_cnt_q, best_cnt_d;
  logic [CLS_W-1:0]      best_idx_q, best_idx_d;
  logic [CLS_W-1:0]      class_idx_q, class_idx_d;
  logic                  class_valid_q, class_valid_d;

  logic                  is_first;
  logic                  is_last;
  logic [ACC_W-1:0]      f_len;
  logic [X_ADDR_LEN-1:0] f_last;
  logic [X_ADDR_LEN-1:0] n_last;
  logic [ACC_W-1:0]      match;
  logic                  act_bit;

  assign is_first = (layer_q == '0);
  assign is_last  = (layer_q == LAST_LAYER);
  assign f_len    = is_first ? IN_F : HID_F;
  assign f_last   = is_first ? IN_LAST : HID_LAST;
  assign n_last   = is_last ? OUT_LAST : HID_LAST;
  assign match    = {{(ACC_W-1){1'b0}}, ~(bus.w_data ^ bus.x_rd_data)};
  // Sign activation: popcount of at least half the fan-in, ties resolve to 1.
  assign act_bit  = ({acc_q, 1'b0} >= {1'b0, f_len});

  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    neuron_d      = neuron_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    base_d        = base_q;
    best_cnt_d    = best_cnt_q;
    best_idx_d    = best_idx_q;
    class_idx_d   = class_idx_q;
    class_valid_d = class_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_LOAD;
          layer_d       = '0;
          neuron_d      = '0;
          idx_d         = '0;
          acc_d         = '0;
          base_d        = '0;
          best_cnt_d    = '0;
          best_idx_d    = '0;
          class_valid_d = 1'b0;
        end
      end

      S_LOAD: begin
        idx_d = idx_q + X_ADDR_LEN'(1);
        // Memory returns data one cycle late, so the first LOAD has nothing to add.
        if (idx_q != '0) begin
          acc_d = acc_q + match;
        end
        if (idx_q == f_last) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        acc_d   = acc_q + match;
        state_d = S_EMIT;
      end

      S_EMIT: begin
        if (is_last && ((neuron_q == '0) || (acc_q > best_cnt_q))) begin
          best_cnt_d = acc_q;
          best_idx_d = CLS_W'(neuron_q);
        end
        acc_d = '0;
        idx_d = '0;
        if (neuron_q == n_last) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            layer_d  = layer_q + SEL_LEN'(1);
            neuron_d = '0;
            base_d   = '0;
            state_d  = S_LOAD;
          end
        end else begin
          neuron_d = neuron_q + X_ADDR_LEN'(1);
          base_d   = base_q + W_ADDR_LEN'(f_len);
          state_d  = S_LOAD;
        end
      end

      S_DONE: begin
        class_idx_d   = best_idx_q;
        class_valid_d = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      layer_q       <= '0;
      neuron_q      <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      base_q        <= '0;
      best_cnt_q    <= '0;
      best_idx_q    <= '0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      neuron_q      <= neuron_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      base_q        <= base_d;
      best_cnt_q    <= best_cnt_d;
      best_idx_q    <= best_idx_d;
      class_idx_q   <= class_idx_d;
      class_valid_q <= class_valid_d;
    end
  end

  // Outputs decode registered state only, so reset forces them low immediately.
  logic in_load, in_layer, in_write;

  assign in_load  = (state_q == S_LOAD);
  assign in_layer = (state_q == S_LOAD) || (state_q == S_DRAIN) || (state_q == S_EMIT);
  assign in_write = (state_q == S_EMIT) && !is_last;

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.class_idx   = class_idx_q;
  assign bus.class_valid = class_valid_q;
  assign bus.w_addr      = in_load ? (base_q + W_ADDR_LEN'(idx_q)) : '0;
  assign bus.w_sel       = in_layer ? layer_q : '0;
  assign bus.x_addr      = in_load ? idx_q : (in_write ? neuron_q : '0);
  assign bus.x_sel       = in_write ? (layer_q + SEL_LEN'(1)) :
                           ((in_load || (state_q == S_DRAIN)) ? layer_q : '0);
  assign bus.x_wr_en     = in_write;
  assign bus.x_wr_data   = in_write & act_bit;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench: a tiny 3-layer instance with hand-computed results and a
// 4-layer medium instance with random memories checked against a behavioural model.
module tb_bnn_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  bnn_layer_sequencer_if #(.W_ADDR_LEN(20), .X_ADDR_LEN(10), .SEL_LEN(2), .CLS_W(4)) bus_s ();
  bnn_layer_sequencer_if #(.W_ADDR_LEN(20), .X_ADDR_LEN(10), .SEL_LEN(2), .CLS_W(4)) bus_m ();

  bnn_layer_sequencer #(
    .NUM_LAYERS(3), .IN_LEN(2), .HID_LEN(3), .OUT_LEN(2),
    .W_ADDR_LEN(20), .X_ADDR_LEN(10), .SEL_LEN(2), .ACC_W(11), .CLS_W(4)
  ) u_small (.clk(clk), .rst(rst), .bus(bus_s));

  bnn_layer_sequencer #(
    .NUM_LAYERS(4), .IN_LEN(12), .HID_LEN(16), .OUT_LEN(10),
    .W_ADDR_LEN(20), .X_ADDR_LEN(10), .SEL_LEN(2), .ACC_W(11), .CLS_W(4)
  ) u_med (.clk(clk), .rst(rst), .bus(bus_m));

  // Memories: weights and input bank written by the stimulus, hidden banks by the DUT.
  logic wmem_s [0:3][0:15];
  logic xin_s  [0:15];
  logic xwr_s  [0:3][0:15];
  logic wmem_m [0:3][0:255];
  logic xin_m  [0:15];
  logic xwr_m  [0:3][0:15];

  int done_cnt_s = 0;
  int wr_cnt_s [0:3] = '{default: 0};
  int ones_s = 0;
  int bad_wr_s = 0;
  int done_cnt_m = 0;
  int wr_tot_m = 0;
  int bad_wr_m = 0;
  int max_w_m [0:3] = '{default: 0};

  always @(posedge clk) begin
    bus_s.w_data    <= wmem_s[bus_s.w_sel][bus_s.w_addr[3:0]];
    bus_s.x_rd_data <= (bus_s.x_sel == 2'd0) ? xin_s[bus_s.x_addr[3:0]]
                                             : xwr_s[bus_s.x_sel][bus_s.x_addr[3:0]];
    if (bus_s.x_wr_en) xwr_s[bus_s.x_sel][bus_s.x_addr[3:0]] <= bus_s.x_wr_data;
  end

  always @(posedge clk) begin
    bus_m.w_data    <= wmem_m[bus_m.w_sel][bus_m.w_addr[7:0]];
    bus_m.x_rd_data <= (bus_m.x_sel == 2'd0) ? xin_m[bus_m.x_addr[3:0]]
                                             : xwr_m[bus_m.x_sel][bus_m.x_addr[3:0]];
    if (bus_m.x_wr_en) xwr_m[bus_m.x_sel][bus_m.x_addr[3:0]] <= bus_m.x_wr_data;
  end

  always @(posedge clk) begin
    if (bus_s.done) done_cnt_s <= done_cnt_s + 1;
    if (bus_s.x_wr_en) begin
      wr_cnt_s[bus_s.x_sel] <= wr_cnt_s[bus_s.x_sel] + 1;
      if (bus_s.x_wr_data) ones_s <= ones_s + 1;
      if (bus_s.x_sel != bus_s.w_sel + 2'd1 || bus_s.w_sel == 2'd2) bad_wr_s <= bad_wr_s + 1;
    end
    if (bus_m.done) done_cnt_m <= done_cnt_m + 1;
    if (bus_m.x_wr_en) begin
      wr_tot_m <= wr_tot_m + 1;
      if (bus_m.x_sel != bus_m.w_sel + 2'd1 || bus_m.w_sel == 2'd3) bad_wr_m <= bad_wr_m + 1;
    end
    if (bus_m.busy && int'(bus_m.w_addr) > max_w_m[bus_m.w_sel])
      max_w_m[bus_m.w_sel] <= int'(bus_m.w_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_s(input bit spam, output int cyc, output int dn);
    int d0;
    d0  = done_cnt_s;
    cyc = -1;
    @(negedge clk);
    bus_s.start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      bus_s.start = spam && (c == 3 || c == 13 || c == 30);
      if (bus_s.done) begin
        cyc = c;
        break;
      end
    end
    bus_s.start = 1'b0;
    @(negedge clk);
    check("small_done_one_cycle", {31'd0, bus_s.done}, 32'd0);
    dn = done_cnt_s - d0;
  endtask

  task automatic model_m(output int cls, output logic [15:0] h3);
    logic act [0:15];
    logic nxt [0:15];
    int f, n, cnt, best;
    for (int i = 0; i < 16; i++) act[i] = (i < 12) ? xin_m[i] : 1'b0;
    for (int i = 0; i < 16; i++) nxt[i] = 1'b0;
    best = 0;
    cls  = 0;
    h3   = '0;
    for (int l = 0; l < 4; l++) begin
      f = (l == 0) ? 12 : 16;
      n = (l == 3) ? 10 : 16;
      for (int j = 0; j < n; j++) begin
        cnt = 0;
        for (int i = 0; i < f; i++) if (wmem_m[l][j*f+i] == act[i]) cnt++;
        if (l < 3) begin
          nxt[j] = (2 * cnt >= f);
          if (l == 2) h3[j] = nxt[j];
        end else if (j == 0 || cnt > best) begin
          best = cnt;
          cls  = j;
        end
      end
      for (int i = 0; i < 16; i++) act[i] = nxt[i];
    end
  endtask

  int cyc, dn, w0, w1, w2, b0, o0, wt, exp_cls;
  logic [15:0] exp_h3, obs_h3;

  initial begin
    bus_s.start = 1'b0;
    bus_m.start = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) wmem_s[b][a] = 1'b1;
    for (int a = 0; a < 16; a++) xin_s[a] = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) wmem_m[b][a] = 1'($urandom_range(0, 1));
    for (int a = 0; a < 16; a++) xin_m[a] = 1'($urandom_range(0, 1));

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus_s.busy}, 0);
    check("rst_done", {31'd0, bus_s.done}, 0);
    check("rst_class_valid", {31'd0, bus_s.class_valid}, 0);
    check("rst_class_idx", {28'd0, bus_s.class_idx}, 0);
    check("rst_x_wr_en", {31'd0, bus_s.x_wr_en}, 0);
    check("rst_w_addr", {12'd0, bus_s.w_addr}, 0);
    check("rst_x_addr", {22'd0, bus_s.x_addr}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All ones: every popcount is full, last-layer tie picks class 0.
    w1 = wr_cnt_s[1]; w2 = wr_cnt_s[2]; b0 = bad_wr_s; o0 = ones_s;
    run_s(1'b0, cyc, dn);
    $display("run all_ones: cycles=%0d class=%0d", cyc, bus_s.class_idx);
    check("ones_done_cycle", cyc, 38);
    check("ones_done_count", dn, 1);
    check("ones_class_idx", {28'd0, bus_s.class_idx}, 0);
    check("ones_class_valid", {31'd0, bus_s.class_valid}, 1);
    check("ones_wr_bank1", wr_cnt_s[1] - w1, 3);
    check("ones_wr_bank2", wr_cnt_s[2] - w2, 3);
    check("ones_wr_data_one", ones_s - o0, 6);
    check("ones_bad_writes", bad_wr_s - b0, 0);

    // Last layer: neuron 0 weights zero (count 0), neuron 1 ones (count 3).
    for (int a = 0; a < 3; a++) wmem_s[2][a] = 1'b0;
    run_s(1'b0, cyc, dn);
    $display("run argmax_n1: cycles=%0d class=%0d", cyc, bus_s.class_idx);
    check("argmax_class_idx", {28'd0, bus_s.class_idx}, 1);
    check("argmax_class_valid", {31'd0, bus_s.class_valid}, 1);
    check("argmax_done_cycle", cyc, 38);

    // Start pulses while busy must be ignored; rerun afterwards must match.
    run_s(1'b1, cyc, dn);
    $display("run start_spam: cycles=%0d dones=%0d class=%0d", cyc, dn, bus_s.class_idx);
    check("spam_done_cycle", cyc, 38);
    check("spam_done_count", dn, 1);
    check("spam_class_idx", {28'd0, bus_s.class_idx}, 1);
    check("spam_still_idle", {31'd0, bus_s.busy}, 0);
    run_s(1'b0, cyc, dn);
    $display("run repeat: cycles=%0d class=%0d", cyc, bus_s.class_idx);
    check("repeat_done_cycle", cyc, 38);
    check("repeat_class_idx", {28'd0, bus_s.class_idx}, 1);

    // Threshold at F=2: counts 1 (tie -> 1), 0 (-> 0), 2 (-> 1).
    xin_s[0] = 1'b1; xin_s[1] = 1'b0;
    wmem_s[0][0] = 1'b1; wmem_s[0][1] = 1'b1;
    wmem_s[0][2] = 1'b0; wmem_s[0][3] = 1'b1;
    wmem_s[0][4] = 1'b1; wmem_s[0][5] = 1'b0;
    for (int a = 0; a < 6; a++) wmem_s[2][a] = 1'b1;
    run_s(1'b0, cyc, dn);
    $display("run threshold: bank1=%0d%0d%0d class=%0d", xwr_s[1][0], xwr_s[1][1], xwr_s[1][2], bus_s.class_idx);
    check("tie_acc1_writes1", {31'd0, xwr_s[1][0]}, 1);
    check("zero_acc_writes0", {31'd0, xwr_s[1][1]}, 0);
    check("full_acc_writes1", {31'd0, xwr_s[1][2]}, 1);
    check("layer1_acc2_of3", {31'd0, xwr_s[2][0]}, 1);
    check("threshold_class_idx", {28'd0, bus_s.class_idx}, 0);

    // Abort in layer 1 via asynchronous reset, then a clean run (expect class 1).
    xin_s[1] = 1'b1;
    for (int a = 0; a < 6; a++) wmem_s[0][a] = 1'b1;
    for (int a = 0; a < 3; a++) wmem_s[2][a] = 1'b0;
    run_s(1'b0, cyc, dn);
    check("pre_abort_class_idx", {28'd0, bus_s.class_idx}, 1);
    @(negedge clk);
    bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    repeat (13) @(negedge clk);
    check("abort_in_layer1", {30'd0, bus_s.w_sel}, 1);
    check("abort_busy_before", {31'd0, bus_s.busy}, 1);
    rst = 1'b1;
    #1;
    $display("abort: busy=%0d wr_en=%0d valid=%0d", bus_s.busy, bus_s.x_wr_en, bus_s.class_valid);
    check("abort_busy", {31'd0, bus_s.busy}, 0);
    check("abort_x_wr_en", {31'd0, bus_s.x_wr_en}, 0);
    check("abort_class_valid", {31'd0, bus_s.class_valid}, 0);
    check("abort_class_idx", {28'd0, bus_s.class_idx}, 0);
    wt = wr_cnt_s[1] + wr_cnt_s[2];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_writes", wr_cnt_s[1] + wr_cnt_s[2] - wt, 0);
    check("abort_stays_idle", {31'd0, bus_s.busy}, 0);
    run_s(1'b0, cyc, dn);
    $display("run after_abort: cycles=%0d class=%0d", cyc, bus_s.class_idx);
    check("after_abort_cycle", cyc, 38);
    check("after_abort_class", {28'd0, bus_s.class_idx}, 1);
    check("after_abort_valid", {31'd0, bus_s.class_valid}, 1);

    // Medium 4-layer instance with random memories.
    model_m(exp_cls, exp_h3);
    w0 = done_cnt_m;
    cyc = -1;
    @(negedge clk);
    bus_m.start = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      bus_m.start = 1'b0;
      if (bus_m.done) begin
        cyc = c;
        break;
      end
    end
    bus_m.start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) obs_h3[i] = xwr_m[3][i];
    $display("run medium: cycles=%0d class=%0d expected=%0d", cyc, bus_m.class_idx, exp_cls);
    check("med_done_cycle", cyc, 981);
    check("med_done_count", done_cnt_m - w0, 1);
    check("med_class_idx", {28'd0, bus_m.class_idx}, exp_cls);
    check("med_class_valid", {31'd0, bus_m.class_valid}, 1);
    check("med_hidden_bank3", {16'd0, obs_h3}, {16'd0, exp_h3});
    check("med_max_waddr_l0", max_w_m[0], 191);
    check("med_max_waddr_l1", max_w_m[1], 255);
    check("med_max_waddr_l2", max_w_m[2], 255);
    check("med_max_waddr_l3", max_w_m[3], 159);
    check("med_write_total", wr_tot_m, 48);
    check("med_bad_writes", bad_wr_m, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
